// File: rtl/mcycle_ctrl.sv
// mcycle_ctrl: multicycle control unit for the ARM-subset datapath.
//   Decodes the latched instruction and runs a Moore FSM through
//   fetch/decode/execute/memory/writeback. It holds the NZCV flag register
//   and evaluates the condition field.
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   Instr[31:0]           instruction register contents
//   ALUFlags[3:0]         {N,Z,C,V} from the ALU, sampled on leaving execute states
//   PCWrite, MemWrite, RegWrite, IRWrite, FPUWrite   write enables (0 during reset)
//   AdrSrc, RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl   datapath selects
//   RegSrc64b, Src_64b    multiply register remap / 64-bit writeback
// Configuration: define MCYCLE_CTRL_FPU_EN to include FP decode and the FPEX/FPWB states.
module mcycle_ctrl #(
  parameter int unsigned STATE_W = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        IRWrite,
  output logic        AdrSrc,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ImmSrc,
  output logic [2:0]  ALUControl,
  output logic        RegSrc64b,
  output logic        Src_64b,
  output logic        FPUWrite
);

  typedef enum logic [STATE_W-1:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXR, EXI, ALUWB, BRANCH, MULEX, MULWB
`ifdef MCYCLE_CTRL_FPU_EN
    , FPEX, FPWB
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  flags_q, flags_d;   // {N,Z,C,V}
  logic        cond_q, cond_d;

  logic [1:0]  op;
  logic [3:0]  cmd;
  logic        s_bit;
  logic        is_mul;
  logic        is_cmp;
  logic        cv_cmd;
  logic [2:0]  dp_alu;
  logic [2:0]  mul_alu;
  logic        cond_ex;
  logic        fl_n, fl_z, fl_c, fl_v;
  logic        unused_instr;

  assign op      = Instr[27:26];
  assign cmd     = Instr[24:21];
  assign s_bit   = Instr[20];
  assign is_mul  = (Instr[27:24] == 4'b0000) && (Instr[7:4] == 4'b1001);
  assign is_cmp  = (cmd == 4'b1010);
  assign cv_cmd  = (cmd == 4'b0100) || (cmd == 4'b0010) || is_cmp;
  assign mul_alu = Instr[23] ? (Instr[22] ? 3'b110 : 3'b101) : 3'b100;
  assign ImmSrc  = Instr[27:26];
  assign RegSrc  = {op == 2'b01, op == 2'b10};
  assign {fl_n, fl_z, fl_c, fl_v} = flags_q;
  assign unused_instr = ^{Instr[19:16], Instr[11:8], Instr[3:0]};

  always_comb begin
    dp_alu = 3'b000;
    unique case (cmd)
      4'b0010, 4'b1010: dp_alu = 3'b001;
      4'b0000:          dp_alu = 3'b010;
      4'b1100:          dp_alu = 3'b011;
      default:          dp_alu = 3'b000;
    endcase
  end

  always_comb begin
    cond_ex = 1'b0;
    unique case (Instr[31:28])
      4'b0000: cond_ex = fl_z;
      4'b0001: cond_ex = ~fl_z;
      4'b0010: cond_ex = fl_c;
      4'b0011: cond_ex = ~fl_c;
      4'b0100: cond_ex = fl_n;
      4'b0101: cond_ex = ~fl_n;
      4'b0110: cond_ex = fl_v;
      4'b0111: cond_ex = ~fl_v;
      4'b1000: cond_ex = fl_c & ~fl_z;
      4'b1001: cond_ex = ~fl_c | fl_z;
      4'b1010: cond_ex = (fl_n == fl_v);
      4'b1011: cond_ex = (fl_n != fl_v);
      4'b1100: cond_ex = ~fl_z & (fl_n == fl_v);
      4'b1101: cond_ex = fl_z | (fl_n != fl_v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      flags_q <= '0;
      cond_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
      cond_q  <= cond_d;
    end
  end

  always_comb begin
    state_d    = FETCH;
    flags_d    = flags_q;
    cond_d     = cond_q;
    PCWrite    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    IRWrite    = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUControl = 3'b000;
    RegSrc64b  = 1'b0;
    Src_64b    = 1'b0;
    FPUWrite   = 1'b0;

    // Flags are captured on the edge that leaves an execute state.
    if (((state_q == EXR) || (state_q == EXI) || (state_q == MULEX)) && s_bit && cond_q) begin
      flags_d[3:2] = ALUFlags[3:2];
      if ((state_q != MULEX) && cv_cmd) flags_d[1:0] = ALUFlags[1:0];
    end

    case (state_q)
      FETCH: begin
        ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10;
        IRWrite = 1'b1;  PCWrite = 1'b1;
        state_d = DECODE;
      end
      DECODE: begin
        ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10;
        cond_d  = cond_ex;
        unique case (op)
          2'b01:   state_d = MEMADR;
          2'b10:   state_d = BRANCH;
          2'b00:   state_d = is_mul ? MULEX : (Instr[25] ? EXI : EXR);
`ifdef MCYCLE_CTRL_FPU_EN
          default: state_d = ((Instr[27:24] == 4'b1110) && (Instr[11:9] == 3'b101)) ? FPEX : FETCH;
`else
          default: state_d = FETCH;
`endif
        endcase
      end
      MEMADR: begin
        ALUSrcB = 2'b01;
        state_d = Instr[20] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        AdrSrc  = 1'b1;
        state_d = MEMWB;
      end
      MEMWR: begin
        AdrSrc   = 1'b1;
        MemWrite = cond_q;
        state_d  = FETCH;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = cond_q;
        PCWrite   = cond_q && (Instr[15:12] == 4'hF);
        state_d   = FETCH;
      end
      EXR: begin
        ALUControl = dp_alu;
        state_d    = ALUWB;
      end
      EXI: begin
        ALUSrcB    = 2'b01;
        ALUControl = dp_alu;
        state_d    = ALUWB;
      end
      ALUWB: begin
        RegWrite = cond_q & ~is_cmp;
        PCWrite  = cond_q & ~is_cmp & (Instr[15:12] == 4'hF);
        state_d  = FETCH;
      end
      BRANCH: begin
        ALUSrcA = 2'b01; ALUSrcB = 2'b01; ResultSrc = 2'b10;
        PCWrite = cond_q;
        state_d = FETCH;
      end
      MULEX: begin
        RegSrc64b  = 1'b1;
        ALUControl = mul_alu;
        state_d    = MULWB;
      end
      MULWB: begin
        RegSrc64b = 1'b1;
        RegWrite  = cond_q;
        Src_64b   = Instr[23];
        state_d   = FETCH;
      end
`ifdef MCYCLE_CTRL_FPU_EN
      FPEX: state_d = FPWB;
      FPWB: begin
        FPUWrite = cond_q;
        state_d  = FETCH;
      end
`endif
      default: state_d = FETCH;
    endcase

    // FETCH is the reset state; keep its enables from firing while reset is held.
    if (reset) begin
      PCWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      IRWrite  = 1'b0;
      FPUWrite = 1'b0;
    end
  end

endmodule

// File: tb/tb_mcycle_ctrl.sv
module tb_mcycle_ctrl;
  logic        clk;
  logic        reset;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
  logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
  logic [2:0]  ALUControl;
  logic        RegSrc64b, Src_64b, FPUWrite;

  int checks = 0;
  int failures = 0;

  mcycle_ctrl #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite), .IRWrite(IRWrite),
    .AdrSrc(AdrSrc), .RegSrc(RegSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
    .RegSrc64b(RegSrc64b), .Src_64b(Src_64b), .FPUWrite(FPUWrite)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    reset = 1'b1; Instr = 32'h0; ALUFlags = 4'h0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({PCWrite, MemWrite, RegWrite, IRWrite, FPUWrite} !== 5'b00000) begin
        failures++;
        $display("FAIL reset_we cyc=%0d got=%b exp=00000", i,
                 {PCWrite, MemWrite, RegWrite, IRWrite, FPUWrite});
      end
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({PCWrite, IRWrite} !== 2'b11) begin
      failures++; $display("FAIL first_fetch pcw_irw got=%b exp=11", {PCWrite, IRWrite});
    end
  endtask

  task automatic test_adds();
    Instr = 32'hE2921005; ALUFlags = 4'b0100; #1;
    step();
    checks++;
    if ({PCWrite, IRWrite} !== 2'b00) begin
      failures++; $display("FAIL adds_decode pcw_irw got=%b exp=00", {PCWrite, IRWrite});
    end
    step();
    checks++;
    if ({ALUControl, ALUSrcB} !== {3'b000, 2'b01}) begin
      failures++; $display("FAIL adds_exi aluctl_srcb got=%b exp=00001", {ALUControl, ALUSrcB});
    end
    step();
    checks++;
    if ({RegWrite, PCWrite, ResultSrc} !== 4'b1000) begin
      failures++; $display("FAIL adds_aluwb rw_pcw_rs got=%b exp=1000", {RegWrite, PCWrite, ResultSrc});
    end
    step();
    checks++;
    if (IRWrite !== 1'b1) begin
      failures++; $display("FAIL adds_latency irw got=%b exp=1", IRWrite);
    end
  endtask

  task automatic test_beq_taken(input string tag);
    Instr = 32'h0A000002; ALUFlags = 4'h0; #1;
    step();
    step();
    checks++;
    if ({PCWrite, ALUSrcA, ALUSrcB} !== 5'b10101) begin
      failures++; $display("FAIL %s branch pcw_srca_srcb got=%b exp=10101", tag, {PCWrite, ALUSrcA, ALUSrcB});
    end
    step();
  endtask

  task automatic test_add_nos();
    // S=0: flags must keep Z=1 even though the ALU reports zero flags.
    Instr = 32'hE2821005; ALUFlags = 4'b0000; #1;
    step(); step(); step(); step();
    test_beq_taken("beq_after_nos");
  endtask

  task automatic test_cmp();
    Instr = 32'hE3510000; ALUFlags = 4'b0000; #1;
    step(); step();
    checks++;
    if (ALUControl !== 3'b001) begin
      failures++; $display("FAIL cmp_exi aluctl got=%b exp=001", ALUControl);
    end
    step();
    checks++;
    if (RegWrite !== 1'b0) begin
      failures++; $display("FAIL cmp_aluwb rw got=%b exp=0", RegWrite);
    end
    step();
  endtask

  task automatic test_beq_not_taken();
    Instr = 32'h0A000002; ALUFlags = 4'h0; #1;
    step(); step();
    checks++;
    if (PCWrite !== 1'b0) begin
      failures++; $display("FAIL beq_nt branch pcw got=%b exp=0", PCWrite);
    end
    step();
    checks++;
    if (IRWrite !== 1'b1) begin
      failures++; $display("FAIL beq_nt refetch irw got=%b exp=1", IRWrite);
    end
  endtask

  task automatic test_ldr();
    Instr = 32'hE5910008; #1;
    step(); step();
    checks++;
    if ({ALUSrcA, ALUSrcB, ALUControl} !== 7'b0001000) begin
      failures++; $display("FAIL ldr_memadr got=%b exp=0001000", {ALUSrcA, ALUSrcB, ALUControl});
    end
    step();
    checks++;
    if ({AdrSrc, ResultSrc, RegWrite} !== 4'b1000) begin
      failures++; $display("FAIL ldr_memrd adr_rs_rw got=%b exp=1000", {AdrSrc, ResultSrc, RegWrite});
    end
    step();
    checks++;
    if ({ResultSrc, RegWrite, PCWrite} !== 4'b0110) begin
      failures++; $display("FAIL ldr_memwb rs_rw_pcw got=%b exp=0110", {ResultSrc, RegWrite, PCWrite});
    end
    step();
    checks++;
    if (IRWrite !== 1'b1) begin
      failures++; $display("FAIL ldr_latency irw got=%b exp=1", IRWrite);
    end
  endtask

  task automatic test_str();
    Instr = 32'hE5810008; #1;
    step(); step(); step();
    checks++;
    if ({MemWrite, AdrSrc, RegWrite} !== 3'b110) begin
      failures++; $display("FAIL str_memwr mw_adr_rw got=%b exp=110", {MemWrite, AdrSrc, RegWrite});
    end
    step();
    checks++;
    if (IRWrite !== 1'b1) begin
      failures++; $display("FAIL str_latency irw got=%b exp=1", IRWrite);
    end
  endtask

  task automatic test_umull();
    Instr = 32'hE0821293; #1;
    step(); step();
    checks++;
    if ({ALUControl, RegSrc64b, RegWrite} !== 5'b10110) begin
      failures++; $display("FAIL umull_mulex got=%b exp=10110", {ALUControl, RegSrc64b, RegWrite});
    end
    step();
    checks++;
    if ({RegSrc64b, Src_64b, RegWrite} !== 3'b111) begin
      failures++; $display("FAIL umull_mulwb got=%b exp=111", {RegSrc64b, Src_64b, RegWrite});
    end
    step();
    checks++;
    if (IRWrite !== 1'b1) begin
      failures++; $display("FAIL umull_latency irw got=%b exp=1", IRWrite);
    end
  endtask

  task automatic test_fp();
    Instr = 32'hEE310A02; #1;
    step(); step();
`ifdef MCYCLE_CTRL_FPU_EN
    checks++;
    if ({FPUWrite, IRWrite} !== 2'b00) begin
      failures++; $display("FAIL fp_fpex fpw_irw got=%b exp=00", {FPUWrite, IRWrite});
    end
    step();
    checks++;
    if (FPUWrite !== 1'b1) begin
      failures++; $display("FAIL fp_fpwb fpw got=%b exp=1", FPUWrite);
    end
    step();
`else
    checks++;
    if ({FPUWrite, IRWrite} !== 2'b01) begin
      failures++; $display("FAIL fp_nop fpw_irw got=%b exp=01", {FPUWrite, IRWrite});
    end
`endif
    checks++;
    if ({IRWrite, FPUWrite} !== 2'b10) begin
      failures++; $display("FAIL fp_refetch irw_fpw got=%b exp=10", {IRWrite, FPUWrite});
    end
  endtask

  task automatic test_pc_write();
    Instr = 32'hE282F005; ALUFlags = 4'h0; #1;
    step(); step(); step();
    checks++;
    if ({RegWrite, PCWrite} !== 2'b11) begin
      failures++; $display("FAIL pc_wb rw_pcw got=%b exp=11", {RegWrite, PCWrite});
    end
    step();
  endtask

  task automatic test_reset_mid();
    Instr = 32'hE2921005; ALUFlags = 4'b0100; #1;
    step(); step(); step();
    reset = 1'b1; #1;
    checks++;
    if ({RegWrite, PCWrite, IRWrite} !== 3'b000) begin
      failures++; $display("FAIL midreset we got=%b exp=000", {RegWrite, PCWrite, IRWrite});
    end
    step();
    reset = 1'b0; #1;
    checks++;
    if ({PCWrite, IRWrite} !== 2'b11) begin
      failures++; $display("FAIL midreset fetch got=%b exp=11", {PCWrite, IRWrite});
    end
    // Flags were cleared, so BEQ must not be taken.
    Instr = 32'h0A000002; ALUFlags = 4'h0; #1;
    step(); step();
    checks++;
    if (PCWrite !== 1'b0) begin
      failures++; $display("FAIL midreset flags beq pcw got=%b exp=0", PCWrite);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_adds();
    test_beq_taken("beq_after_adds");
    test_add_nos();
    test_cmp();
    test_beq_not_taken();
    test_ldr();
    test_str();
    test_umull();
    test_fp();
    test_pc_write();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
